seven_seg_scan: RTL

- Parametrised, time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
- Full hex (0-F) decode, per-digit decimal point, active-low segment and anode outputs.
- Double-buffered display data: new values are committed only at frame boundaries, so the display never tears.
- Sits between datapath status registers and the board display pins; it is the multi-digit, clocked successor of the single-digit combinational decoder.

---
 rtl/seven_seg_scan.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//   Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
//   Full hex decode, per-digit decimal point, active-low segment/anode outputs.
//   Display data is double-buffered (shadow -> active). The active copy only
//   changes at a frame boundary, so a frame never mixes old and new values.
//
//   Optional build macro: SEVEN_SEG_LZB_EN enables leading-zero blanking.
//   Blanked digits keep their anode and decimal point. Digit 0 is never blanked.
//
// Parameters
//   NUM_DIGITS   number of multiplexed digits (1..8)
//   REFRESH_DIV  clock cycles each digit stays selected (>= 2)
//   GUARD        all-anodes-off cycles at the start of each slot (< REFRESH_DIV)
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   synchronous active-low reset
//   data_in     in   hex nibbles, digit i = data_in[4i+3:4i], digit 0 rightmost
//   dp_in       in   decimal point request per digit, 1 = lit
//   load        in   one-cycle strobe capturing data_in/dp_in into the shadow
//   seg_n       out  segments a..g on bits 0..6, active-low
//   dp_n        out  decimal point, active-low
//   an_n        out  digit select, active-low, one-hot-low while a digit is driven
//   frame_done  out  one-cycle pulse on the cycle the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seven_seg_scan #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_done
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W:0]   GUARD_LEN = (CNT_W + 1)'(GUARD);

   function automatic logic [6:0] hex_to_seg_n(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic                    pending_q, pending_d;
   logic [4*NUM_DIGITS-1:0] active_q, active_d;
   logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
   logic [6:0]              seg_n_q, seg_n_d;
   logic                    dp_n_q, dp_n_d;
   logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
   logic                    frame_done_q, frame_done_d;

   logic                    slot_end;
   logic                    boundary;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [NUM_DIGITS-1:0]   an_sel_n;
`ifdef SEVEN_SEG_LZB_EN
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   lzb;
`endif

   always_comb begin
      // Scan position
      slot_end = (cnt_q == CNT_LAST);
      boundary = slot_end && (idx_q == IDX_LAST);
      cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
      idx_d    = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      // frame_done is a flop, so it is pre-decoded from the next position to
      // be high exactly during the wrap cycle.
      frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);

      // Shadow / active buffering
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      pending_d   = pending_q;
      active_d    = active_q;
      active_dp_d = active_dp_q;
      if (load) begin
         shadow_d    = data_in;
         shadow_dp_d = dp_in;
         pending_d   = 1'b1;
      end
      if (boundary) begin
         // A load landing on the boundary goes straight to the active copy.
         if (load) begin
            active_d    = data_in;
            active_dp_d = dp_in;
         end else if (pending_q) begin
            active_d    = shadow_q;
            active_dp_d = shadow_dp_q;
         end
         pending_d = 1'b0;
      end

`ifdef SEVEN_SEG_LZB_EN
      // A digit is blank when it and every digit above it are zero.
      zero_run = 1'b1;
      lzb      = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run && (active_q[4*i +: 4] == 4'h0);
         lzb[i]   = zero_run;
      end
`endif

      // Select the digit currently being scanned
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      an_sel_n  = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib     = active_q[4*i +: 4];
            cur_dp      = active_dp_q[i];
            an_sel_n[i] = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
            cur_blank   = lzb[i];
`endif
         end
      end

      // Registered outputs; all-off during the guard window
      if ({1'b0, cnt_q} < GUARD_LEN) begin
         an_n_d  = '1;
         seg_n_d = 7'h7F;
         dp_n_d  = 1'b1;
      end else begin
         an_n_d  = an_sel_n;
         seg_n_d = cur_blank ? 7'h7F : hex_to_seg_n(cur_nib);
         dp_n_d  = ~cur_dp;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         shadow_dp_q  <= '0;
         pending_q    <= 1'b0;
         active_q     <= '0;
         active_dp_q  <= '0;
         seg_n_q      <= 7'h7F;
         dp_n_q       <= 1'b1;
         an_n_q       <= '1;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         shadow_dp_q  <= shadow_dp_d;
         pending_q    <= pending_d;
         active_q     <= active_d;
         active_dp_q  <= active_dp_d;
         seg_n_q      <= seg_n_d;
         dp_n_q       <= dp_n_d;
         an_n_q       <= an_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg_n      = seg_n_q;
   assign dp_n       = dp_n_q;
   assign an_n       = an_n_q;
   assign frame_done = frame_done_q;

endmodule
